// File: rtl/load_store_unit_pkg.sv
// Shared constants and state encoding for the load/store unit and data memory.
package load_store_unit_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned IMM_W = 12;

  localparam logic [2:0] SUP_MEM  = 3'b011;
  localparam logic [2:0] SUP_IDLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory access port: the load/store unit is the master, main_memory the slave.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 64
) ();

  logic [2:0]      mem_sup;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_store_address;
  logic [XLEN-1:0] mem_load_address;
  logic [XLEN-1:0] mem_store_data;
  logic [XLEN-1:0] mem_load_data;

  modport master (
    output mem_sup, mem_read, mem_write,
    output mem_store_address, mem_load_address, mem_store_data,
    input  mem_load_data
  );

  modport slave (
    input  mem_sup, mem_read, mem_write,
    input  mem_store_address, mem_load_address, mem_store_data,
    output mem_load_data
  );

endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding ld/sd initiator: forms base+offset word address, range-checks it,
// and runs the IDLE/ISSUE/WAIT/DONE handshake with the data memory. All outputs registered.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN  = load_store_unit_pkg::XLEN,
  parameter int unsigned DEPTH = load_store_unit_pkg::DEPTH,
  parameter int unsigned IMM_W = load_store_unit_pkg::IMM_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic [XLEN-1:0]         base,
  input  logic [IMM_W-1:0]        offset,
  input  logic [XLEN-1:0]         store_data,
  output logic                    busy,
  output logic                    done,
  output logic [XLEN-1:0]         rd_data,
  output logic                    addr_err,
  load_store_unit_if.master       mem
);

  lsu_state_e      state_q, state_d;
  logic            is_load_q, is_load_d;
  logic [XLEN-1:0] ea_q, ea_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            addr_err_q, addr_err_d;
  logic [2:0]      sup_q, sup_d;
  logic            read_q, read_d;
  logic            write_q, write_d;

  logic [XLEN-1:0] ea_calc;
  logic            req_valid;

  assign ea_calc   = base + {{(XLEN-IMM_W){offset[IMM_W-1]}}, offset};
  assign req_valid = start && (is_load ^ is_store);

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    ea_d      = ea_q;
    sdata_d   = sdata_q;
    rd_data_d = rd_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_load_d = is_load;
          ea_d      = ea_calc;
          sdata_d   = store_data;
          state_d   = (ea_calc >= XLEN'(DEPTH)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = is_load_q ? ST_WAIT : ST_DONE;
      ST_WAIT: begin
        rd_data_d = mem.mem_load_data;
        state_d   = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    addr_err_d = (state_q == ST_IDLE) && (state_d == ST_DONE);
    sup_d      = (state_d == ST_ISSUE) ? SUP_MEM : SUP_IDLE;
    read_d     = (state_d == ST_ISSUE) && is_load_d;
    write_d    = (state_d == ST_ISSUE) && !is_load_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_load_q  <= 1'b0;
      ea_q       <= '0;
      sdata_q    <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      sup_q      <= SUP_IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      ea_q       <= ea_d;
      sdata_q    <= sdata_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      sup_q      <= sup_d;
      read_q     <= read_d;
      write_q    <= write_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign addr_err              = addr_err_q;
  assign rd_data               = rd_data_q;
  assign mem.mem_sup           = sup_q;
  assign mem.mem_read          = read_q;
  assign mem.mem_write         = write_q;
  assign mem.mem_store_address = ea_q;
  assign mem.mem_load_address  = ea_q;
  assign mem.mem_store_data    = sdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory and a done scoreboard.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    logic        err;
    logic        load;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [63:0] base = '0;
  logic [11:0] offset = '0;
  logic [63:0] store_data = '0;
  logic        busy, done, addr_err;
  logic [63:0] rd_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  exp_t        sb_q[$];
  logic [63:0] mem_arr [DEPTH];

  load_store_unit_if #(.XLEN(64)) mif ();

  load_store_unit #(.XLEN(64), .DEPTH(32), .IMM_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .rd_data    (rd_data),
    .addr_err   (addr_err),
    .mem        (mif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: samples on mem_sup==3'b011, load data registered one cycle later.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;
    mem_arr[5] = 64'hDEAD_BEEF_0000_0001;
    mif.mem_load_data = '0;
  end

  always @(posedge clk) begin
    if (mif.mem_sup == 3'b011) begin
      if (mif.mem_write) mem_arr[mif.mem_store_address[4:0]] <= mif.mem_store_data;
      if (mif.mem_read)  mif.mem_load_data <= mem_arr[mif.mem_load_address[4:0]];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_addr_err", {63'd0, addr_err}, {63'd0, e.err});
        if (e.load && !e.err) check_eq("sb_rd_data", rd_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic err, input logic ld, input logic [63:0] d);
    exp_t e;
    e.err = err; e.load = ld; e.data = d;
    sb_q.push_back(e);
  endtask

  // Drives start for one sampling edge; returns in cycle 1.
  task automatic do_req(input logic ld, input logic st, input logic [63:0] b,
                        input logic [11:0] off, input logic [63:0] sd);
    is_load = ld; is_store = st; base = b; offset = off; store_data = sd;
    start = 1'b1;
    tick();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned at_cyc);
    int unsigned n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    at_cyc = cyc;
    if (done !== 1'b1) check_eq("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
    check_eq({tag, "_err"},  {63'd0, addr_err}, 64'd0);
    check_eq({tag, "_sup"},  {61'd0, mif.mem_sup}, 64'd0);
    check_eq({tag, "_rw"},   {62'd0, mif.mem_read, mif.mem_write}, 64'd0);
    check_eq({tag, "_rd"},   rd_data, 64'd0);
    check_eq({tag, "_sadr"}, mif.mem_store_address, 64'd0);
    check_eq({tag, "_ladr"}, mif.mem_load_address, 64'd0);
    check_eq({tag, "_sdat"}, mif.mem_store_data, 64'd0);
  endtask

  initial begin
    int unsigned t1, t2;

    tick(); tick();
    reset = 1'b0;
    check_reset_state("rst");

    // Load word 5 via base 3 + offset 2.
    push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    do_req(1'b1, 1'b0, 64'd3, 12'd2, 64'd0);
    check_eq("ld_c1_read", {63'd0, mif.mem_read}, 64'd1);
    check_eq("ld_c1_addr", mif.mem_load_address, 64'd5);
    check_eq("ld_c1_sup",  {61'd0, mif.mem_sup}, 64'd3);
    check_eq("ld_c1_busy", {63'd0, busy}, 64'd1);
    tick();
    check_eq("ld_c2_done", {63'd0, done}, 64'd0);
    check_eq("ld_c2_sup",  {61'd0, mif.mem_sup}, 64'd0);
    tick();
    check_eq("ld_c3_done", {63'd0, done}, 64'd1);
    check_eq("ld_c3_rd",   rd_data, 64'hDEAD_BEEF_0000_0001);
    check_eq("ld_c3_err",  {63'd0, addr_err}, 64'd0);
    tick();
    check_eq("ld_idle_busy", {63'd0, busy}, 64'd0);

    // Store to word 9 via base 10 + offset -1.
    push_exp(1'b0, 1'b0, 64'd0);
    do_req(1'b0, 1'b1, 64'd10, 12'hFFF, 64'h1234);
    check_eq("st_c1_write", {63'd0, mif.mem_write}, 64'd1);
    check_eq("st_c1_read",  {63'd0, mif.mem_read}, 64'd0);
    check_eq("st_c1_addr",  mif.mem_store_address, 64'd9);
    check_eq("st_c1_data",  mif.mem_store_data, 64'h1234);
    check_eq("st_c1_sup",   {61'd0, mif.mem_sup}, 64'd3);
    tick();
    check_eq("st_c2_done", {63'd0, done}, 64'd1);
    tick();

    push_exp(1'b0, 1'b1, 64'h1234);
    do_req(1'b1, 1'b0, 64'd9, 12'd0, 64'd0);
    tick(); tick();
    check_eq("ld9_done", {63'd0, done}, 64'd1);
    check_eq("ld9_rd",   rd_data, 64'h1234);
    tick();

    // Out-of-range: ea = 32.
    push_exp(1'b1, 1'b1, 64'd0);
    do_req(1'b1, 1'b0, 64'd30, 12'd2, 64'd0);
    check_eq("err_c1_done", {63'd0, done}, 64'd1);
    check_eq("err_c1_err",  {63'd0, addr_err}, 64'd1);
    check_eq("err_c1_sup",  {61'd0, mif.mem_sup}, 64'd0);
    check_eq("err_c1_rw",   {62'd0, mif.mem_read, mif.mem_write}, 64'd0);
    check_eq("err_rd_hold", rd_data, 64'h1234);
    tick();
    check_eq("err_c2_busy", {63'd0, busy}, 64'd0);
    check_eq("err_c2_sup",  {61'd0, mif.mem_sup}, 64'd0);

    // Invalid requests: both and neither op bits.
    do_req(1'b1, 1'b1, 64'd3, 12'd2, 64'd0);
    check_eq("inv_both_busy", {63'd0, busy}, 64'd0);
    check_eq("inv_both_sup",  {61'd0, mif.mem_sup}, 64'd0);
    do_req(1'b0, 1'b0, 64'd3, 12'd2, 64'd0);
    check_eq("inv_none_busy", {63'd0, busy}, 64'd0);
    tick();

    // start during WAIT must be ignored.
    push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    do_req(1'b1, 1'b0, 64'd5, 12'd0, 64'd0);
    tick();
    is_load = 1'b1; base = 64'd9; start = 1'b1;
    tick();
    start = 1'b0; is_load = 1'b0;
    check_eq("wst_done", {63'd0, done}, 64'd1);
    check_eq("wst_rd",   rd_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    check_eq("wst_idle1", {63'd0, busy}, 64'd0);
    tick();
    check_eq("wst_idle2", {63'd0, busy}, 64'd0);

    // Reset during WAIT: no done, all outputs return to reset values.
    do_req(1'b1, 1'b0, 64'd9, 12'd0, 64'd0);
    tick();
    check_eq("rw_in_wait", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rw");
    tick(); tick(); tick();
    check_eq("rw_still_idle", {63'd0, busy}, 64'd0);

    // Back-to-back loads: second done exactly 4 cycles after first.
    push_exp(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    push_exp(1'b0, 1'b1, 64'h1234);
    do_req(1'b1, 1'b0, 64'd5, 12'd0, 64'd0);
    wait_done(10, t1);
    tick();
    do_req(1'b1, 1'b0, 64'd9, 12'd0, 64'd0);
    wait_done(10, t2);
    check_eq("b2b_gap", 64'(t2 - t1), 64'd4);
    tick(); tick();

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
